// File: rtl/ram64_seq_loader.sv
// ram64_seq_loader
//   Command-driven sequencer placed directly in front of a RAM64 block. It owns
//   the RAM in/load/address pins and turns block commands into one-word-per-cycle
//   accesses:
//     FILL  (00) : write a constant over [base, base+len)
//     WRITE (01) : write a valid/ready byte stream over [base, base+len)
//     READ  (10) : stream [base, base+len) out with zero read latency
//     11         : reserved, accepted and completed without any RAM access
//   Addresses wrap modulo 2**AW.
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake (ready only in IDLE)
//   cmd_op/base/len/fill       : command fields (len 0..2**AW)
//   wr_valid/wr_ready/wr_data  : write stream (ready while in WRITE)
//   rd_valid/rd_ready/rd_data  : read stream (valid while in READ)
//   ram_in/ram_load/ram_address: to RAM64
//   ram_out                    : from RAM64
//   busy                       : not IDLE
//   done                       : one-cycle pulse at command completion
module ram64_seq_loader #(
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_base,
    input  logic [AW:0]      cmd_len,
    input  logic [WIDTH-1:0] cmd_fill,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] ram_in,
    output logic             ram_load,
    output logic [AW-1:0]    ram_address,
    input  logic [WIDTH-1:0] ram_out,
    output logic             busy,
    output logic             done
);

    localparam int LW = AW + 1;

    localparam logic [1:0] OP_FILL  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t           state;
    logic [AW-1:0]    ptr;
    logic [LW-1:0]    remaining;
    logic [WIDTH-1:0] fill_reg;
    logic             xfer;

    // One word moves per cycle in FILL; WRITE/READ move only on a handshake.
    always_comb begin
        xfer = 1'b0;
        case (state)
            S_FILL:  xfer = 1'b1;
            S_WRITE: xfer = wr_valid;
            S_READ:  xfer = rd_ready;
            default: xfer = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            remaining <= '0;
            fill_reg  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        ptr       <= cmd_base;
                        remaining <= cmd_len;
                        fill_reg  <= cmd_fill;
                        if (cmd_len == '0 || cmd_op == 2'b11)
                            state <= S_DONE;
                        else if (cmd_op == OP_FILL)
                            state <= S_FILL;
                        else if (cmd_op == OP_WRITE)
                            state <= S_WRITE;
                        else
                            state <= S_READ;
                    end
                end
                S_FILL, S_WRITE, S_READ: begin
                    if (xfer) begin
                        ptr       <= ptr + AW'(1);
                        remaining <= remaining - LW'(1);
                        if (remaining == LW'(1))
                            state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign wr_ready    = (state == S_WRITE);
    assign rd_valid    = (state == S_READ);
    assign rd_data     = ram_out;
    assign ram_address = ptr;

    // Gating with reset stops the in-flight word from landing on the edge
    // that aborts the command, so only words completed before reset remain.
    assign ram_load = !reset && ((state == S_FILL) || (state == S_WRITE && wr_valid));

    always_comb begin
        ram_in = '0;
        case (state)
            S_FILL:  ram_in = fill_reg;
            S_WRITE: ram_in = wr_data;
            default: ram_in = '0;
        endcase
    end

endmodule

// File: tb/tb_ram64_seq_loader.sv
module tb_ram64_seq_loader;

    localparam logic [1:0] OP_FILL  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [5:0] cmd_base = '0;
    logic [6:0] cmd_len = '0;
    logic [7:0] cmd_fill = '0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready = 1'b0;
    logic [7:0] ram_in;
    logic       ram_load;
    logic [5:0] ram_address;
    logic [7:0] ram_out;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    ram64_seq_loader #(.WIDTH(8), .AW(6)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
        .ram_out(ram_out), .busy(busy), .done(done)
    );

    // RAM64 behavioural model: combinational read, write on rising edge.
    logic [7:0] mem [64];
    logic       preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (ram_load) begin
            mem[ram_address] <= ram_in;
        end
    end
    assign ram_out = mem[ram_address];

    // Expected memory contents, maintained independently by the bench.
    logic [7:0] exp_mem [64];
    logic [7:0] wdata [4];
    logic [7:0] rd_log [$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  base;
        logic [6:0]  len;
        logic [7:0]  fill;
        logic [31:0] vpat;       // bit c = wr_valid/rd_ready in cycle c after accept
        int          exp_cycles; // cycles from accept to the done pulse, inclusive
        logic        chk_rd;
        logic [31:0] exp_rd;     // first four read words, packed MSB first
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input vec_t v);
        int         rem;
        int         cyc;
        int         k;
        logic [5:0] p;
        logic       hs;
        logic       exp_load;
        logic [7:0] exp_in;
        rd_log.delete();
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_op = v.op; cmd_base = v.base; cmd_len = v.len; cmd_fill = v.fill;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        // Keep offering a conflicting command while busy; it must be ignored.
        cmd_op = OP_FILL; cmd_base = 6'd33; cmd_len = 7'd64; cmd_fill = 8'hFF;
        rem = (v.op == OP_RSVD) ? 0 : int'(v.len);
        p = v.base; cyc = 0; k = 0;
        while (rem > 0 && cyc < 200) begin
            @(negedge clk);
            hs = (cyc < 32) ? v.vpat[cyc] : 1'b1;
            wr_valid = (v.op == OP_WRITE) && hs;
            rd_ready = (v.op == OP_READ) && hs;
            wr_data  = wdata[k % 4];
            #1;
            exp_load = (v.op == OP_FILL) || (v.op == OP_WRITE && hs);
            check("ram_load", 32'(ram_load), 32'(exp_load));
            check("ram_address", 32'(ram_address), 32'(p));
            check("busy_active", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            if (exp_load) begin
                exp_in = (v.op == OP_FILL) ? v.fill : wdata[k % 4];
                check("ram_in", 32'(ram_in), 32'(exp_in));
                exp_mem[p] = exp_in;
            end
            if (v.op == OP_WRITE) check("wr_ready", 32'(wr_ready), 32'd1);
            if (v.op == OP_READ) begin
                check("rd_valid", 32'(rd_valid), 32'd1);
                check("rd_data", 32'(rd_data), 32'(exp_mem[p]));
                if (hs) rd_log.push_back(rd_data);
            end
            if (v.op == OP_FILL || hs) begin
                p = p + 6'd1; rem--; k++;
            end
            cyc++;
        end
        if (rem > 0) check("cmd_timeout", 32'(rem), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        #1;
        cyc++;
        check("done_pulse", 32'(done), 32'd1);
        check("cmd_ready_done", 32'(cmd_ready), 32'd0);
        check("load_in_done", 32'(ram_load), 32'd0);
        check("cycles_to_done", 32'(cyc), 32'(v.exp_cycles));
        @(negedge clk); #1;
        check("done_single", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("cmd_ready_after", 32'(cmd_ready), 32'd1);
    endtask

    task automatic compare_mem(input string name);
        int bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i * 7 + 3);

        //          op        base   len    fill   vpat          cyc chk   exp_rd
        vecs[0] = '{OP_FILL,  6'd0,  7'd64, 8'hA5, 32'hFFFFFFFF, 65, 1'b0, 32'h0};
        vecs[1] = '{OP_READ,  6'd0,  7'd64, 8'h00, 32'hFFFFFFFF, 65, 1'b0, 32'h0};
        vecs[2] = '{OP_WRITE, 6'd62, 7'd4,  8'h00, 32'hFFFFFFFF, 5,  1'b0, 32'h0};
        vecs[3] = '{OP_READ,  6'd62, 7'd4,  8'h00, 32'h00000035, 7,  1'b1, 32'h11223344};
        vecs[4] = '{OP_WRITE, 6'd10, 7'd3,  8'h00, 32'h00000019, 6,  1'b0, 32'h0};
        vecs[5] = '{OP_FILL,  6'd5,  7'd0,  8'h77, 32'hFFFFFFFF, 1,  1'b0, 32'h0};
        vecs[6] = '{OP_RSVD,  6'd5,  7'd7,  8'h77, 32'hFFFFFFFF, 1,  1'b0, 32'h0};
        vecs[7] = '{OP_READ,  6'd10, 7'd3,  8'h00, 32'hFFFFFFFF, 4,  1'b0, 32'h0};
        vecs[8] = '{OP_FILL,  6'd60, 7'd6,  8'h5A, 32'hFFFFFFFF, 7,  1'b0, 32'h0};

        // Reset state, observed while reset is still asserted.
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ram_load", 32'(ram_load), 32'd0);
        check("rst_ram_address", 32'(ram_address), 32'd0);
        check("rst_ram_in", 32'(ram_in), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        reset = 1'b0; preload = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
            if (vecs[i].chk_rd) begin
                check("rd_count", 32'(rd_log.size()), 32'd4);
                if (rd_log.size() == 4)
                    check("rd_order", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]}, vecs[i].exp_rd);
            end
        end

        // Spot values after the sequence above, derived by hand.
        check("addr2_kept", 32'(mem[2]), 32'hA5);
        check("addr12_write", 32'(mem[12]), 32'h33);
        check("addr59_kept", 32'(mem[59]), 32'hA5);
        check("addr62_refill", 32'(mem[62]), 32'h5A);
        check("addr1_refill", 32'(mem[1]), 32'h5A);
        compare_mem("mem_after_vectors");

        // Reset part-way through a 64-word FILL.
        @(negedge clk);
        cmd_op = OP_FILL; cmd_base = 6'd0; cmd_len = 7'd64; cmd_fill = 8'hC3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            check("abort_load", 32'(ram_load), 32'd1);
            check("abort_addr", 32'(ram_address), 32'(c));
            exp_mem[c] = 8'hC3;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_load_in_reset", 32'(ram_load), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_addr_zero", 32'(ram_address), 32'd0);
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) dn++;
            @(negedge clk); #1;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        compare_mem("mem_after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
